// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared types and constants for the debug memory responder
//
// Purpose: FSM state encoding, the data word returned for out-of-range debug
// reads, and the largest supported memory read latency.
// Ports: none (package).

package debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RD_HOLD = 2'd2,
    ST_WR      = 2'd3
  } dbg_state_e;

  localparam logic [31:0] BAD_ADDR_DATA  = 32'hDEADBEEF;
  localparam int          MAX_RD_LATENCY = 4;

endpackage

// File: rtl/debug_mem_responder.sv
// rtl/debug_mem_responder.sv - debug-port arbiter and read/write sequencer for one memory
//
// Purpose: while the CPU runs, the memory port follows the CPU combinationally.
// While the CPU is halted, a debug host reads and writes the memory through
// dbg_*. Reads wait RD_LATENCY cycles and then present data with a held ready.
// Writes go through a one-cycle registered WR state.
// Optional macro DEBUG_MEM_RANGE_CHECK_EN: debug accesses beyond ADDR_WORDS
// never reach the memory. Reads of such addresses return BAD_ADDR_DATA, and
// writes to them are dropped.
//
// Ports:
//   cpu_clk, cpu_rst              clock, synchronous active-high reset
//   cpu_halt                      CPU halted; debug owns the memory port
//   dbg_ce, dbg_we                debug access enable, single-cycle write strobe
//   dbg_addr, dbg_wdata           debug byte address, write data
//   dbg_rdata, dbg_rdata_ready    debug read data, read data valid (held)
//   cpu_addr, cpu_wdata, cpu_we   CPU byte address, write data, write
//   cpu_rdata                     CPU read data (always mem_rdata)
//   mem_en, mem_we, mem_addr      memory strobe, write, word index
//   mem_wdata, mem_rdata          memory write data, read data (RD_LATENCY later)

module debug_mem_responder
  import debug_pkg::*;
#(
  parameter int ADDR_WORDS = 16384,
  parameter int RD_LATENCY = 1
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        cpu_halt,
  input  logic        dbg_ce,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_rdata_ready,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  output logic [31:0] cpu_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int            AW       = $clog2(ADDR_WORDS);
  localparam int            CW       = $clog2(MAX_RD_LATENCY);
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_LATENCY - 1);

  dbg_state_e    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ready_q, ready_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        dbg_active, wr_req, rd_req, addr_changed, issue_rd;
  logic        dbg_oob, lat_oob;
  logic [31:0] cpu_idx, dbg_idx, lat_idx;
  logic        unused_cpu_addr_bits;

  // Word indices keep only the low clog2(ADDR_WORDS) bits, so they wrap.
  assign cpu_idx = {{(32-AW){1'b0}}, cpu_addr[AW+1:2]};
  assign dbg_idx = {{(32-AW){1'b0}}, dbg_addr[AW+1:2]};
  assign lat_idx = {{(32-AW){1'b0}}, addr_q[AW+1:2]};
  assign unused_cpu_addr_bits = ^{cpu_addr[31:AW+2], cpu_addr[1:0]};

`ifdef DEBUG_MEM_RANGE_CHECK_EN
  assign dbg_oob = ({2'b00, dbg_addr[31:2]} >= 32'(ADDR_WORDS));
  assign lat_oob = ({2'b00, addr_q[31:2]} >= 32'(ADDR_WORDS));
`else
  assign dbg_oob = 1'b0;
  assign lat_oob = 1'b0;
`endif

  assign dbg_active   = cpu_halt & dbg_ce;
  assign wr_req       = dbg_active & dbg_we;
  assign rd_req       = dbg_active & ~dbg_we;
  assign addr_changed = (dbg_addr != addr_q);
  // A read goes out from IDLE, or again from RD_HOLD when the host moves on.
  assign issue_rd = rd_req & ((state_q == ST_IDLE) |
                              ((state_q == ST_RD_HOLD) & addr_changed));

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = ready_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_req) begin
          state_d = ST_WR;
          addr_d  = dbg_addr;
          wdata_d = dbg_wdata;
        end else if (rd_req) begin
          state_d = ST_RD_WAIT;
          addr_d  = dbg_addr;
          cnt_d   = '0;
        end
      end
      ST_RD_WAIT: begin
        if (!dbg_active) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (dbg_we) begin
          // A write strobe preempts the read so it is never lost.
          state_d = ST_WR;
          addr_d  = dbg_addr;
          wdata_d = dbg_wdata;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RD_HOLD;
          rdata_d = lat_oob ? BAD_ADDR_DATA : mem_rdata;
          ready_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RD_HOLD: begin
        if (!dbg_active) begin
          state_d = ST_IDLE;
          ready_d = 1'b0;
        end else if (dbg_we) begin
          state_d = ST_WR;
          ready_d = 1'b0;
          addr_d  = dbg_addr;
          wdata_d = dbg_wdata;
        end else if (addr_changed) begin
          state_d = ST_RD_WAIT;
          ready_d = 1'b0;
          addr_d  = dbg_addr;
          cnt_d   = '0;
        end
      end
      ST_WR: begin
        // Back-to-back strobes re-register and stay here for another write.
        if (wr_req) begin
          addr_d  = dbg_addr;
          wdata_d = dbg_wdata;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!cpu_halt) begin
      rdata_d = '0;
      ready_d = 1'b0;
    end
  end

  // A registered write finishes even if halt falls. Reset hands the port back
  // to the CPU at once.
  always_comb begin
    mem_en    = 1'b1;
    mem_we    = cpu_we;
    mem_addr  = cpu_idx;
    mem_wdata = cpu_wdata;
    if (!cpu_rst) begin
      if (state_q == ST_WR) begin
        mem_en    = ~lat_oob;
        mem_we    = ~lat_oob;
        mem_addr  = lat_idx;
        mem_wdata = wdata_q;
      end else if (cpu_halt) begin
        mem_en    = issue_rd & ~dbg_oob;
        mem_we    = 1'b0;
        mem_addr  = dbg_idx;
        mem_wdata = wdata_q;
      end
    end
  end

  assign dbg_rdata       = rdata_q;
  assign dbg_rdata_ready = ready_q;
  assign cpu_rdata       = mem_rdata;

endmodule
